fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream.sv | 53 +++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a one-cycle-latency FIFO read port into a bubble-free valid/ready stream
module fifo_rd_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    output logic             fifo_ren,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_level
);
    logic [1:0]       level_q, level_d, wr_idx;
    logic             inflight_q, inflight_d, push, pop;
    logic [WIDTH-1:0] buf_q [3];
    logic [WIDTH-1:0] buf_d [3];

    assign out_valid = level_q != 2'd0;
    assign out_data  = buf_q[0];
    assign out_level = level_q;

    always_comb begin
        fifo_ren   = !srst && !flush && !fifo_rempty && ({1'b0, level_q} + {2'b0, inflight_q} < 3'd3);
        pop        = out_valid && out_ready;
        push       = inflight_q && !flush;
        inflight_d = fifo_ren;
        level_d    = flush ? 2'd0 : level_q + {1'b0, push} - {1'b0, pop};
        wr_idx     = level_q - {1'b0, pop};
        buf_d      = buf_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        if (push) buf_d[wr_idx] = fifo_rdata;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            level_q    <= 2'd0;
            inflight_q <= 1'b0;
            buf_q      <= '{default: '0};
        end else begin
            level_q    <= level_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
        end
    end

    assert property (@(posedge clk) disable iff (srst) !(push && !pop && level_q == 2'd3));
endmodule
